rv32im_dmem_resp: RTL
=====================

// Module: rv32im_dmem_resp
// PURPOSE
//  Data-memory responder on the memory side of the LSU interface. Accepts one
//  load/store request at a time and performs byte/half/word access on a
//  word-wide internal RAM with a configurable wait count. Returns read data
//  right-aligned, so the LSU can sign- or zero-extend from bit 0, plus an error
//  flag. Sits between the LSU and the core's data address space.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words (power of two)
//  BASE_ADDR    32'h0000_2000  byte address of word 0
//  WAIT_CYCLES  0     extra BUSY cycles between accept and response (0..15)
// PORTS
//  clk_i        in   1   clock, all state on rising edge
//  rst_i        in   1   asynchronous, active-high reset
//  req_valid_i  in   1   request present
//  req_ready_o  out  1   responder can accept (high only in IDLE)
//  req_we_i     in   1   1=store, 0=load
//  req_size_i   in   2   0=byte, 1=half, 2=word, 3=illegal
//  req_addr_i   in   `API_ADDR_WIDTH  byte address
//  req_wdata_i  in   `API_DATA_WIDTH  store data, right-aligned (LSU format)
//  rsp_valid_o  out  1   response present
//  rsp_ready_i  in   1   LSU takes response
//  rsp_rdata_o  out  `API_DATA_WIDTH  load data shifted to bit 0; upper bytes raw
//  rsp_err_o    out  1   misaligned, out of range or illegal size
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait cnt=0.
//   RAM contents are not reset. Reset mid-transaction drops it; a store already
//   committed stays written.
//  FSM: IDLE -> (valid&ready) -> BUSY if WAIT_CYCLES>0, else RESP.
//   BUSY counts WAIT_CYCLES cycles, then RESP.
//   RESP holds rsp_* stable until rsp_ready_i=1, then IDLE.
//  req_ready_o = (state==IDLE); no accept in the same cycle as the RESP handshake.
//  Offset off=addr[1:0]; word index = (addr-BASE_ADDR)>>2.
//  Error if: size=3; size=1 & off[0]; size=2 & off!=0;
//   addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS. On error: no write,
//   rsp_rdata_o=0, rsp_err_o=1.
//  Store: commits at accept edge. Byte enables are 0001/0011/1111 << off,
//   write data is req_wdata_i << 8*off. Unselected bytes are unchanged.
//   rsp_rdata_o=0.
//  Load: RAM word read at accept edge; rsp_rdata_o = word >> 8*off (zero fill
//   on top). Load latency = 1+WAIT_CYCLES cycles from accept to rsp_valid_o.
//  Request inputs are sampled only at the accept edge and ignored otherwise.
//  Store followed by a load to the same address returns the new data
//   (no hazard: one outstanding request).
// TESTING
//  SW 0xDEADBEEF @0x2000, then LW @0x2000 -> rdata 0xDEADBEEF, err 0,
//   rsp_valid 1 cycle after accept (WAIT=0).
//  SB 0x000000AA @0x2002 over 0xDEADBEEF, LW @0x2000 -> 0xDEAABEEF;
//   LB @0x2002 -> rdata[7:0]=0xAA.
//  SH @0x2001 -> err 1, memory unchanged; LW @0x1FFC and
//   LW @BASE+4*DEPTH -> err 1, rdata 0.
//  WAIT_CYCLES=3: LW accepted at cycle 0 -> rsp_valid at cycle 4;
//   req_ready_o 0 during cycles 1-4.
//  Hold rsp_ready_i=0 for 5 cycles -> rsp_valid/rdata/err stable, req_ready_o
//   0; release -> IDLE next cycle.
//  Assert rst_i in BUSY -> outputs 0 immediately; next LW returns the prior
//   word content.

Source files
------------

// File: rtl/rv32im_dmem_resp.sv
// Data-memory responder for the LSU: one request at a time, byte/half/word
// access to a word-wide RAM, optional wait states, right-aligned load data.
`ifndef API_ADDR_WIDTH
`define API_ADDR_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

module rv32im_dmem_resp #(
  parameter int                         DEPTH_WORDS = 1024,
  parameter logic [`API_ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_2000,
  parameter int                         WAIT_CYCLES = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [1:0]                 req_size_i,
  input  logic [`API_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [`API_DATA_WIDTH-1:0] req_wdata_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [`API_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic [1:0]                 dbg_state_o
);

  // Handshake: a request transfers on the rising edge where req_valid_i and
  // req_ready_o are both high; a response transfers where rsp_valid_o and
  // rsp_ready_i are both high. Neither side may retract before its transfer.

  localparam int             AW     = `API_ADDR_WIDTH;
  localparam int             DW     = `API_DATA_WIDTH;
  localparam int             NB     = DW / 8;
  localparam int             IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]  SPAN   = AW'(4 * DEPTH_WORDS);
  localparam logic [3:0]     LAST   = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic [DW-1:0]    r_rdata;
  logic             r_err;
  logic [DW-1:0]    r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic [AW-1:0]    w_rel;
  logic             w_in_range;
  logic [1:0]       w_off;
  logic             w_err;
  logic [NB-1:0]    w_be;
  logic [DW-1:0]    w_wdata;
  logic [IDX_W-1:0] w_idx;
  logic [DW-1:0]    w_rd_shift;

  assign w_accept   = req_valid_i && (r_state == S_IDLE);
  assign w_rel      = req_addr_i - BASE_ADDR;
  assign w_in_range = (req_addr_i >= BASE_ADDR) && (w_rel < SPAN);
  assign w_off      = req_addr_i[1:0];
  assign w_idx      = w_rel[IDX_W+1:2];
  assign w_wdata    = req_wdata_i << {w_off, 3'b000};
  assign w_rd_shift = r_mem[w_idx] >> {w_off, 3'b000};

  always_comb begin
    w_err = !w_in_range;
    w_be  = '1;
    case (req_size_i)
      2'd0: w_be = NB'(4'b0001 << w_off);
      2'd1: begin
        w_be = NB'(4'b0011 << w_off);
        if (w_off[0]) w_err = 1'b1;
      end
      2'd2: if (w_off != 2'd0) w_err = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  // RAM is deliberately outside the reset domain: committed stores survive reset.
  always_ff @(posedge clk_i) begin
    if (w_accept && req_we_i && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (WAIT_CYCLES > 0) ? S_BUSY : S_RESP;
      S_BUSY: if (r_cnt == LAST) w_next = S_RESP;
      S_RESP: if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= 4'd0;
      r_err   <= w_err;
      r_rdata <= (w_err || req_we_i) ? '0 : w_rd_shift;
    end else if (r_state == S_BUSY) begin
      r_cnt   <= r_cnt + 4'd1;
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign dbg_state_o = r_state;

endmodule
